// File: rtl/ycr_dmi_hs_pkg.sv
// ycr_dmi_pkg: op/status encodings, DTMCS layout and FSM states for the handshaked DMI
package ycr_dmi_pkg;
  localparam logic [1:0] OP_NOP = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2;
  localparam logic [1:0] ST_SUCCESS = 2'd0, ST_FAILED = 2'd2, ST_BUSY = 2'd3;
  localparam int DTMCS_LEN = 32;
  localparam int DTMCS_HARDRESET = 17, DTMCS_DMIRESET = 16;
  localparam logic [3:0] DTMCS_VERSION = 4'd1;
  typedef enum logic {IDLE, BUSY} dmi_state_e;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ycr_dmi_hs_if.sv
// ycr_dmi_hs_if: req/resp handshake between the DMI and the Debug Module
interface ycr_dmi_hs_if #(parameter int ADDR_WIDTH = 7, parameter int DATA_WIDTH = 32);
  logic req, wr, resp, err;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  modport master(output req, wr, addr, wdata, input resp, rdata, err);
  modport slave(input req, wr, addr, wdata, output resp, rdata, err);
endinterface

// File: rtl/ycr_dmi_tap_dr.sv
// ycr_dmi_tap_dr: capture/shift data register with two selectable chain lengths
module ycr_dmi_tap_dr #(
  parameter int LEN = 41,
  parameter int LEN_A = 32,
  parameter int LEN_B = 41
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           capture,
  input  logic           shift,
  input  logic           sel_b,
  input  logic           tdi,
  input  logic [LEN-1:0] cap_data,
  output logic [LEN-1:0] dr
);
  logic [LEN-1:0] nxt, sh;
  int top;
  // shift right within the active length, tdi enters its MSB, bits above stay clear
  always_comb begin
    top = (sel_b ? LEN_B : LEN_A) - 1;
    sh = dr >> 1;
    for (int i = 0; i < LEN; i++) nxt[i] = (i == top) ? tdi : (i < top) ? sh[i] : 1'b0;
  end
  // capture has priority over shift
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dr <= '0;
    else if (capture) dr <= cap_data;
    else if (shift) dr <= nxt;
endmodule

// File: rtl/ycr_dmi_hs.sv
// ycr_dmi_hs: DTMCS/DMI chains with a registered req/resp DM handshake, sticky status and timeout
module ycr_dmi_hs import ycr_dmi_pkg::*; #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int CH_ID_WIDTH = 2,
  parameter int DTMCS_ID = 1,
  parameter int DMI_ID = 2,
  parameter int IDLE_CYCLES = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                   rst_n,
  input  logic                   clk,
  input  logic                   tapcsync2dmi_ch_sel_i,
  input  logic [CH_ID_WIDTH-1:0] tapcsync2dmi_ch_id_i,
  input  logic                   tapcsync2dmi_ch_capture_i,
  input  logic                   tapcsync2dmi_ch_shift_i,
  input  logic                   tapcsync2dmi_ch_update_i,
  input  logic                   tapcsync2dmi_ch_tdi_i,
  output logic                   dmi2tapcsync_ch_tdo_o,
  ycr_dmi_hs_if.master           dm
);
  localparam int DMI_LEN = ADDR_WIDTH + DATA_WIDTH + 2;
  localparam int DR_LEN = max2(DTMCS_LEN, DMI_LEN);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  dmi_state_e state;
  logic [1:0] sticky;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] rdata_ff;
  logic [DR_LEN-1:0] dr, cap;
  logic is_dtmcs, is_dmi, dtmcs_upd, dmi_upd, dmi_cap;
  logic [1:0] u_op;
  logic [DATA_WIDTH-1:0] u_data;
  logic [ADDR_WIDTH-1:0] u_addr;

  assign is_dtmcs = tapcsync2dmi_ch_sel_i & (tapcsync2dmi_ch_id_i == CH_ID_WIDTH'(DTMCS_ID));
  assign is_dmi = tapcsync2dmi_ch_sel_i & (tapcsync2dmi_ch_id_i == CH_ID_WIDTH'(DMI_ID));
  assign dtmcs_upd = tapcsync2dmi_ch_update_i & is_dtmcs;
  assign dmi_upd = tapcsync2dmi_ch_update_i & is_dmi;
  assign dmi_cap = tapcsync2dmi_ch_capture_i & is_dmi;
  assign u_op = dr[1:0];
  assign u_data = dr[DATA_WIDTH+1:2];
  assign u_addr = dr[DMI_LEN-1:DATA_WIDTH+2];
  assign dmi2tapcsync_ch_tdo_o = dr[0];

  // capture image: DMI reports busy while an access is outstanding, else the sticky status
  always_comb begin
    cap = '0;
    if (is_dmi) cap[DMI_LEN-1:0] = {dm.addr, rdata_ff, (state == BUSY) ? ST_BUSY : sticky};
    else begin
      cap[3:0] = DTMCS_VERSION;
      cap[9:4] = 6'(ADDR_WIDTH);
      cap[11:10] = sticky;
      cap[14:12] = 3'(IDLE_CYCLES);
    end
  end

  ycr_dmi_tap_dr #(.LEN(DR_LEN), .LEN_A(DTMCS_LEN), .LEN_B(DMI_LEN)) u_dr (
    .clk(clk),
    .rst_n(rst_n),
    .capture(tapcsync2dmi_ch_capture_i & (is_dtmcs | is_dmi)),
    .shift(tapcsync2dmi_ch_shift_i & (is_dtmcs | is_dmi)),
    .sel_b(is_dmi),
    .tdi(tapcsync2dmi_ch_tdi_i),
    .cap_data(cap),
    .dr(dr)
  );

  // access FSM: hardreset overrides everything, sticky errors only ever leave SUCCESS
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sticky <= ST_SUCCESS;
      cnt <= '0;
      rdata_ff <= '0;
      dm.req <= 1'b0;
      dm.wr <= 1'b0;
      dm.addr <= '0;
      dm.wdata <= '0;
    end else if (dtmcs_upd && dr[DTMCS_HARDRESET]) begin
      state <= IDLE;
      dm.req <= 1'b0;
      sticky <= ST_SUCCESS;
      cnt <= '0;
    end else begin
      if (dtmcs_upd && dr[DTMCS_DMIRESET]) sticky <= ST_SUCCESS;
      if (state == BUSY && (dmi_cap || dmi_upd) && sticky == ST_SUCCESS) sticky <= ST_BUSY;
      if (state == IDLE) begin
        if (dmi_upd && sticky == ST_SUCCESS && (u_op == OP_READ || u_op == OP_WRITE)) begin
          state <= BUSY;
          dm.req <= 1'b1;
          dm.wr <= u_op == OP_WRITE;
          dm.addr <= u_addr;
          dm.wdata <= u_data;
          cnt <= '0;
        end
      end else if (dm.resp) begin
        state <= IDLE;
        dm.req <= 1'b0;
        cnt <= '0;
        if (dm.err) begin
          if (sticky == ST_SUCCESS) sticky <= ST_FAILED;
        end else if (!dm.wr) rdata_ff <= dm.rdata;
      end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
        state <= IDLE;
        dm.req <= 1'b0;
        cnt <= '0;
        if (sticky == ST_SUCCESS) sticky <= ST_FAILED;
      end else cnt <= cnt + 1'b1;
    end
endmodule
